// File: rtl/ib_fetch_writer_pkg.sv
// Shared types for the instruction-buffer writer.
// IB entry layout, fetch FSM states and address helpers.
package ib_fetch_writer_pkg;

  localparam int          IB_ENTRY_W   = 65;
  localparam int          IB_EXC_BIT   = 64;
  localparam int          IB_PC_LSB    = 32;
  localparam int          IB_INST_LSB  = 0;
  localparam logic [31:0] DEF_RESET_PC = 32'hBFC0_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_PUSH_LO,
    ST_PUSH_HI,
    ST_DROP,
    ST_ERR
  } fetch_state_e;

  typedef struct packed {
    logic        exc;
    logic [31:0] pc;
    logic [31:0] inst;
  } ib_entry_t;

  function automatic ib_entry_t mk_entry(
    input logic        exc,
    input logic [31:0] pc,
    input logic [31:0] inst
  );
    ib_entry_t e;
    e.exc  = exc;
    e.pc   = pc;
    e.inst = inst;
    return e;
  endfunction

  function automatic logic [31:0] line_base(
    input logic [31:0] pc
  );
    return {pc[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/ib_fetch_writer.sv
// Instruction-buffer writer: fetches 64-bit pairs
// from the I-cache and pushes them as IB entries.
module ib_fetch_writer
  import ib_fetch_writer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          ENTRY_W  = IB_ENTRY_W
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               stall,
  input  logic               flush,
  input  logic [31:0]        redirect_pc,
  output logic               icache_req,
  output logic [31:0]        icache_addr,
  input  logic               icache_gnt,
  input  logic               icache_rvalid,
  input  logic [63:0]        icache_rdata,
  output logic [ENTRY_W-1:0] fifo_in,
  output logic               fifo_w_en,
  input  logic               fifo_full
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [63:0]  buf_q, buf_d;
  logic         err_done_q, err_done_d;
  logic         push_ok;
  ib_entry_t    entry;

  // State, fetch PC, response buffer and error-push flag
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      buf_q      <= '0;
      err_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_q      <= buf_d;
      err_done_q <= err_done_d;
    end
  end

  // Next state, request and push generation; flush overrides all
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_d       = buf_q;
    err_done_d  = err_done_q;
    icache_req  = 1'b0;
    icache_addr = '0;
    fifo_w_en   = 1'b0;
    entry       = '0;
    push_ok     = ~fifo_full & ~stall & ~flush;

    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (pc_q[1:0] != 2'b00) begin
          state_d = ST_ERR;
        end else begin
          icache_req  = 1'b1;
          icache_addr = line_base(pc_q);
          if (icache_gnt) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (icache_rvalid) begin
          buf_d   = icache_rdata;
          state_d = pc_q[2] ? ST_PUSH_HI
                            : ST_PUSH_LO;
        end
      end
      ST_PUSH_LO: begin
        entry = mk_entry(1'b0, line_base(pc_q),
                         buf_q[31:0]);
        if (push_ok) begin
          fifo_w_en = 1'b1;
          state_d   = ST_PUSH_HI;
        end
      end
      ST_PUSH_HI: begin
        entry = mk_entry(1'b0, pc_q | 32'd4,
                         buf_q[63:32]);
        if (push_ok) begin
          fifo_w_en = 1'b1;
          pc_d      = line_base(pc_q) + 32'd8;
          state_d   = ST_REQ;
        end
      end
      ST_ERR: begin
        entry = mk_entry(1'b1, pc_q, 32'h0);
        if (push_ok && !err_done_q) begin
          fifo_w_en  = 1'b1;
          err_done_d = 1'b1;
        end
      end
      ST_DROP: begin
        if (icache_rvalid) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_ERR) err_done_d = 1'b0;

    if (flush) begin
      pc_d       = redirect_pc;
      err_done_d = 1'b0;
      unique case (state_q)
        ST_WAIT, ST_DROP:
          state_d = icache_rvalid ? ST_REQ
                                  : ST_DROP;
        ST_REQ:
          state_d = (icache_req && icache_gnt)
                    ? ST_DROP : ST_REQ;
        default: state_d = ST_REQ;
      endcase
    end

    fifo_in = fifo_w_en ? ENTRY_W'(entry) : '0;
  end

endmodule

// File: tb/tb_ib_fetch_writer.sv
// Self-checking bench for ib_fetch_writer.
// Directed scenarios, then random traffic vs a scoreboard.
module tb_ib_fetch_writer;

  logic        clk;
  logic        rst_;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_gnt;
  logic        icache_rvalid;
  logic [63:0] icache_rdata;
  logic [64:0] fifo_in;
  logic        fifo_w_en;
  logic        fifo_full;

  int total;
  int bad;

  // reference model state
  logic [31:0] mpc;
  logic        merr;
  logic [64:0] expq[$];
  logic        out_v;
  logic        out_stale;
  int          out_dly;
  logic [63:0] out_data;

  ib_fetch_writer dut (
    .clk          (clk),
    .rst_         (rst_),
    .stall        (stall),
    .flush        (flush),
    .redirect_pc  (redirect_pc),
    .icache_req   (icache_req),
    .icache_addr  (icache_addr),
    .icache_gnt   (icache_gnt),
    .icache_rvalid(icache_rvalid),
    .icache_rdata (icache_rdata),
    .fifo_in      (fifo_in),
    .fifo_w_en    (fifo_w_en),
    .fifo_full    (fifo_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [64:0] ent(
    input logic        exc,
    input logic [31:0] pc,
    input logic [31:0] inst
  );
    return {exc, pc, inst};
  endfunction

  task automatic chk(input string tag,
                     input logic [64:0] obs,
                     input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // grant the pending request, return data next cycle
  task automatic serve(input logic [63:0] d);
    icache_gnt = 1'b1;
    @(negedge clk);
    icache_gnt    = 1'b0;
    icache_rvalid = 1'b1;
    icache_rdata  = d;
    @(negedge clk);
    icache_rvalid = 1'b0;
  endtask

  function automatic logic [31:0] pick_redirect();
    logic [31:0] r;
    case ($urandom_range(0, 7))
      0: r = 32'hFFFF_FFF8;
      1: r = 32'hFFFF_FFFC;
      2: r = $urandom | 32'h1;
      default: r = $urandom & ~32'h3;
    endcase
    return r;
  endfunction

  // one random cycle: drive, check, advance model
  task automatic rnd_cycle(input bit quiet);
    logic [63:0] d;
    @(negedge clk);
    flush       = !quiet &&
                  ($urandom_range(0, 39) == 0);
    redirect_pc = pick_redirect();
    fifo_full   = !quiet &&
                  ($urandom_range(0, 3) == 0);
    stall       = !quiet &&
                  ($urandom_range(0, 4) == 0);
    if (out_v && out_dly == 0) begin
      icache_rvalid = 1'b1;
      icache_rdata  = out_data;
    end else begin
      icache_rvalid = 1'b0;
      icache_rdata  = {$urandom, $urandom};
      if (out_v) out_dly--;
    end
    icache_gnt = !quiet && icache_req && !out_v &&
                 ($urandom_range(0, 1) == 1);
    #1;
    if (merr) chk("req_in_err", icache_req, 0);
    if (icache_req)
      chk("addr", icache_addr, {mpc[31:3], 3'b000});
    if (fifo_w_en) begin
      chk("push_blocked",
          fifo_full | stall | flush, 0);
      if (expq.size() == 0)
        chk("push_unexpected", fifo_w_en, 0);
      else
        chk("entry", fifo_in, expq.pop_front());
    end else begin
      chk("idle_zero", fifo_in, 0);
    end
    if (icache_rvalid) begin
      out_v = 1'b0;
      if (!flush && !out_stale) begin
        d = icache_rdata;
        if (!mpc[2])
          expq.push_back(ent(1'b0,
            {mpc[31:3], 3'b000}, d[31:0]));
        expq.push_back(ent(1'b0,
          {mpc[31:3], 3'b100}, d[63:32]));
        mpc = {mpc[31:3], 3'b000} + 32'd8;
      end
    end
    if (icache_gnt) begin
      out_v     = 1'b1;
      out_stale = flush;
      out_dly   = $urandom_range(0, 2);
      out_data  = {$urandom, $urandom};
    end
    if (flush) begin
      expq.delete();
      mpc  = redirect_pc;
      merr = |redirect_pc[1:0];
      if (merr)
        expq.push_back(ent(1'b1, redirect_pc, 32'h0));
      if (out_v) out_stale = 1'b1;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_ = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    redirect_pc = '0;
    icache_gnt = 1'b0;
    icache_rvalid = 1'b0;
    icache_rdata = '0;
    fifo_full = 1'b0;
    mpc = 32'hBFC0_0000;
    merr = 1'b0;
    out_v = 1'b0;
    out_stale = 1'b0;
    out_dly = 0;
    out_data = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", icache_req, 0);
    chk("rst_addr", icache_addr, 0);
    chk("rst_wen", fifo_w_en, 0);
    chk("rst_fifo_in", fifo_in, 0);

    // 1: first fetch after reset
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    icache_gnt = 1'b1;
    #1;
    chk("t1_req", icache_req, 1);
    chk("t1_addr", icache_addr, 32'hBFC0_0000);
    @(negedge clk);
    icache_gnt = 1'b0;
    #1 chk("t1_wait_req", icache_req, 0);
    @(negedge clk);
    icache_rvalid = 1'b1;
    icache_rdata  = 64'h2222_2222_1111_1111;
    #1 chk("t1_wait_wen", fifo_w_en, 0);
    @(negedge clk);
    icache_rvalid = 1'b0;
    #1;
    chk("t1_lo_wen", fifo_w_en, 1);
    chk("t1_lo", fifo_in,
        ent(1'b0, 32'hBFC0_0000, 32'h1111_1111));
    @(negedge clk);
    #1;
    chk("t1_hi_wen", fifo_w_en, 1);
    chk("t1_hi", fifo_in,
        ent(1'b0, 32'hBFC0_0004, 32'h2222_2222));
    @(negedge clk);
    #1;
    chk("t1_next_req", icache_req, 1);
    chk("t1_next_addr", icache_addr, 32'hBFC0_0008);

    // 2: redirect to odd word
    flush = 1'b1;
    redirect_pc = 32'h8000_0104;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("t2_req", icache_req, 1);
    chk("t2_addr", icache_addr, 32'h8000_0100);
    serve(64'hAAAA_AAAA_5555_5555);
    #1;
    chk("t2_wen", fifo_w_en, 1);
    chk("t2_hi", fifo_in,
        ent(1'b0, 32'h8000_0104, 32'hAAAA_AAAA));
    @(negedge clk);
    #1;
    chk("t2_one_push", fifo_w_en, 0);
    chk("t2_next_addr", icache_addr, 32'h8000_0108);

    // 3: backpressure during PUSH_LO
    serve(64'h4444_4444_3333_3333);
    for (int i = 0; i < 5; i++) begin
      fifo_full = 1'b1;
      #1 chk("t3_full_hold", fifo_w_en, 0);
      @(negedge clk);
    end
    fifo_full = 1'b0;
    #1;
    chk("t3_lo", fifo_in,
        ent(1'b0, 32'h8000_0108, 32'h3333_3333));
    @(negedge clk);
    #1;
    chk("t3_hi", fifo_in,
        ent(1'b0, 32'h8000_010C, 32'h4444_4444));
    @(negedge clk);
    #1;
    chk("t3_no_dup", fifo_w_en, 0);
    chk("t3_next_addr", icache_addr, 32'h8000_0110);

    // 4: flush while waiting for a response
    icache_gnt = 1'b1;
    @(negedge clk);
    icache_gnt  = 1'b0;
    flush       = 1'b1;
    redirect_pc = 32'h8000_0200;
    #1 chk("t4_flush_wen", fifo_w_en, 0);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("t4_drop_req", icache_req, 0);
    @(negedge clk);
    #1 chk("t4_drop_req2", icache_req, 0);
    @(negedge clk);
    icache_rvalid = 1'b1;
    icache_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    #1 chk("t4_stale_wen", fifo_w_en, 0);
    @(negedge clk);
    icache_rvalid = 1'b0;
    #1;
    chk("t4_stale_wen2", fifo_w_en, 0);
    chk("t4_addr", icache_addr, 32'h8000_0200);
    serve(64'h6666_6666_5555_5555);
    #1;
    chk("t4_lo", fifo_in,
        ent(1'b0, 32'h8000_0200, 32'h5555_5555));
    @(negedge clk);
    #1;
    chk("t4_hi", fifo_in,
        ent(1'b0, 32'h8000_0204, 32'h6666_6666));
    @(negedge clk);
    #1 chk("t4_next_addr", icache_addr, 32'h8000_0208);

    // 5: misaligned redirect
    flush = 1'b1;
    redirect_pc = 32'h8000_0002;
    @(negedge clk);
    flush = 1'b0;
    #1 chk("t5_no_req", icache_req, 0);
    @(negedge clk);
    #1;
    chk("t5_err_wen", fifo_w_en, 1);
    chk("t5_err", fifo_in,
        ent(1'b1, 32'h8000_0002, 32'h0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("t5_hold_wen", fifo_w_en, 0);
      chk("t5_hold_req", icache_req, 0);
    end
    flush = 1'b1;
    redirect_pc = 32'h8000_0300;
    @(negedge clk);
    flush = 1'b0;
    #1 chk("t5_exit_addr", icache_addr, 32'h8000_0300);

    // 6: async reset in PUSH_HI
    serve(64'h8888_8888_7777_7777);
    #1;
    chk("t6_lo", fifo_in,
        ent(1'b0, 32'h8000_0300, 32'h7777_7777));
    @(negedge clk);
    #1 chk("t6_hi_wen", fifo_w_en, 1);
    #2 rst_ = 1'b0;
    #1;
    chk("t6_rst_wen", fifo_w_en, 0);
    chk("t6_rst_req", icache_req, 0);
    chk("t6_rst_fifo_in", fifo_in, 0);
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    #1;
    chk("t6_req", icache_req, 1);
    chk("t6_addr", icache_addr, 32'hBFC0_0000);

    // random traffic against the scoreboard
    mpc = 32'hBFC0_0000;
    merr = 1'b0;
    out_v = 1'b0;
    expq.delete();
    repeat (3000) rnd_cycle(1'b0);
    repeat (30) rnd_cycle(1'b1);
    chk("drain_left", expq.size(), 0);
    chk("drain_outstanding", out_v, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
